// File: rtl/processor_top_pkg.sv
// Shared constants for the RGB sine-fade PWM driver: widths, default phase offsets
// and the quarter-wave sine ROM with its signed-duty helper.
package processor_top_pkg;

    localparam int PWM_WIDTH      = 8;
    localparam int PHASE_WIDTH    = 8;
    localparam int PRESCALE_WIDTH = 20;
    localparam int SINE_ENTRIES   = 65;

    localparam int G_OFFSET_DEFAULT = 85;
    localparam int B_OFFSET_DEFAULT = 171;

    typedef logic [PWM_WIDTH-1:0]   duty_t;
    typedef logic [PHASE_WIDTH-1:0] phase_t;

    // Quarter-wave table: round(127*sin(pi*i/128)) for i = 0..64.
    localparam logic [6:0] SINE_ROM [SINE_ENTRIES] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
        7'd127
    };

    // The low 7 phase bits fold onto the quarter table; bit 7 selects the negative half.
    function automatic duty_t sine_duty(input phase_t p);
        logic [6:0] idx;
        idx = (p[6:0] > 7'd64) ? 7'd0 - p[6:0] : p[6:0];
        return p[7] ? duty_t'(8'd128 - {1'b0, SINE_ROM[idx]})
                    : duty_t'(8'd128 + {1'b0, SINE_ROM[idx]});
    endfunction

endpackage

// File: rtl/processor_top_if.sv
// RGB LED drive bundle; the driver owns the master side, the board/bench the slave side.
interface processor_top_if;

    logic RGB_R;
    logic RGB_G;
    logic RGB_B;

    modport master (output RGB_R, output RGB_G, output RGB_B);
    modport slave  (input  RGB_R, input  RGB_G, input  RGB_B);

endinterface

// File: rtl/processor_top_pwm_channel.sv
// One PWM colour channel: duty latched at the period wrap, registered compare output.
// LED_ACTIVE_LOW_EN selects active-low drive for iCE40 RGB pads.
module pwm_channel
    import processor_top_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wrap,
    input  duty_t pwm_cnt,
    input  duty_t target,
    output logic  led
);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_ON = 1'b0;
`else
    localparam logic LED_ON = 1'b1;
`endif

    duty_t duty;

    // Duty only changes at the period boundary so a period is never split between two levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty <= '0;
            led  <= ~LED_ON;
        end else begin
            if (wrap) begin
                duty <= target;
            end
            led <= (pwm_cnt < duty) ? LED_ON : ~LED_ON;
        end
    end

endmodule

// File: rtl/processor_top.sv
// RGB sine colour-cycle driver: prescaled phase, sine lookup, three PWM channels.
// Define LED_ACTIVE_LOW_EN for active-low LED outputs.
module processor_top
    import processor_top_pkg::*;
#(
    parameter int PWM_BITS    = PWM_WIDTH,
    parameter int STEP_CYCLES = 46875,
    parameter int G_OFFSET    = G_OFFSET_DEFAULT,
    parameter int B_OFFSET    = B_OFFSET_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    processor_top_if.master led
);

    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_LAST = PRESCALE_WIDTH'(STEP_CYCLES - 1);

    logic [PRESCALE_WIDTH-1:0] prescaler;
    logic [PWM_BITS-1:0]       pwm_cnt;
    phase_t                    phase;
    logic                      tick;
    logic                      wrap;
    duty_t                     target_r;
    duty_t                     target_g;
    duty_t                     target_b;

    assign tick = (prescaler == PRESCALE_LAST);
    assign wrap = (pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            phase     <= '0;
            pwm_cnt   <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                phase <= phase + 1'b1;
            end
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // A phase step landing on the wrap edge is seen by the channels one period later.
    assign target_r = sine_duty(phase);
    assign target_g = sine_duty(phase + phase_t'(G_OFFSET));
    assign target_b = sine_duty(phase + phase_t'(B_OFFSET));

    pwm_channel u_red (
        .clk     (clk),
        .reset   (reset),
        .wrap    (wrap),
        .pwm_cnt (pwm_cnt),
        .target  (target_r),
        .led     (led.RGB_R)
    );

    pwm_channel u_green (
        .clk     (clk),
        .reset   (reset),
        .wrap    (wrap),
        .pwm_cnt (pwm_cnt),
        .target  (target_g),
        .led     (led.RGB_G)
    );

    pwm_channel u_blue (
        .clk     (clk),
        .reset   (reset),
        .wrap    (wrap),
        .pwm_cnt (pwm_cnt),
        .target  (target_b),
        .led     (led.RGB_B)
    );

endmodule

// File: tb/tb_processor_top.sv
// Bench for processor_top: three instances (STEP_CYCLES 46875, 4, 1) checked every cycle
// against a closed-form timeline model built on $sin; build with LED_ACTIVE_LOW_EN for inverted pads.
module tb_processor_top;

    localparam real PI = 3.14159265358979;
    localparam int  SLOW_STEP = 46875;
    localparam int  MID_STEP  = 4;
    localparam int  FAST_STEP = 1;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic ON_LVL = 1'b0;
`else
    localparam logic ON_LVL = 1'b1;
`endif

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    bit   checking = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 clk = ~clk;

    processor_top_if slow_if ();
    processor_top_if mid_if ();
    processor_top_if fast_if ();

    processor_top #(.PWM_BITS(8), .STEP_CYCLES(SLOW_STEP), .G_OFFSET(85), .B_OFFSET(171)) dut_slow (
        .clk   (clk),
        .reset (reset),
        .led   (slow_if)
    );

    processor_top #(.PWM_BITS(8), .STEP_CYCLES(MID_STEP), .G_OFFSET(85), .B_OFFSET(171)) dut_mid (
        .clk   (clk),
        .reset (reset),
        .led   (mid_if)
    );

    processor_top #(.PWM_BITS(8), .STEP_CYCLES(FAST_STEP), .G_OFFSET(85), .B_OFFSET(171)) dut_fast (
        .clk   (clk),
        .reset (reset),
        .led   (fast_if)
    );

    // Edges since the last edge that sampled reset high.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic int model_target(input int p);
        real s;
        int  mag;
        s   = $sin(PI * real'(p) / 128.0);
        mag = $rtoi(127.0 * ((s < 0.0) ? -s : s) + 0.5);
        return (s < 0.0) ? 128 - mag : 128 + mag;
    endfunction

    // Output after edge k: the compare made at edge k uses the counter value k-1 and the duty
    // loaded at the last period boundary, whose phase is the one held just before that boundary.
    function automatic logic expected_level(input int k, input int step, input int offset);
        int j;
        int duty;
        int phase;
        if (k == 0) return ~ON_LVL;
        j = k - 1;
        if (j < 256) begin
            duty = 0;
        end else begin
            phase = ((256 * (j / 256) - 1) / step + offset) % 256;
            duty  = model_target(phase);
        end
        return ((j % 256) < duty) ? ON_LVL : ~ON_LVL;
    endfunction

    task automatic check_output(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %b expected %b", name, cyc, actual, expected);
        end
    endtask

    task automatic check_count(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check_output("slow_r", slow_if.RGB_R, expected_level(cyc, SLOW_STEP, 0));
            check_output("slow_g", slow_if.RGB_G, expected_level(cyc, SLOW_STEP, 85));
            check_output("slow_b", slow_if.RGB_B, expected_level(cyc, SLOW_STEP, 171));
            check_output("mid_r",  mid_if.RGB_R,  expected_level(cyc, MID_STEP, 0));
            check_output("mid_g",  mid_if.RGB_G,  expected_level(cyc, MID_STEP, 85));
            check_output("mid_b",  mid_if.RGB_B,  expected_level(cyc, MID_STEP, 171));
            check_output("fast_r", fast_if.RGB_R, expected_level(cyc, FAST_STEP, 0));
            check_output("fast_g", fast_if.RGB_G, expected_level(cyc, FAST_STEP, 85));
            check_output("fast_b", fast_if.RGB_B, expected_level(cyc, FAST_STEP, 171));
        end
    end

    task automatic check_all_off(input string name);
        check_output({name, "_slow_r"}, slow_if.RGB_R, ~ON_LVL);
        check_output({name, "_slow_g"}, slow_if.RGB_G, ~ON_LVL);
        check_output({name, "_slow_b"}, slow_if.RGB_B, ~ON_LVL);
        check_output({name, "_mid_r"},  mid_if.RGB_R,  ~ON_LVL);
        check_output({name, "_fast_r"}, fast_if.RGB_R, ~ON_LVL);
    endtask

    // Hold reset for the given number of edges, check the off level, then release.
    task automatic apply_stimulus(input int reset_cycles, input string name);
        reset = 1'b1;
        repeat (reset_cycles) @(posedge clk);
        @(negedge clk);
        check_all_off(name);
        reset = 1'b0;
    endtask

    // Count on-cycles over the two PWM periods that follow a reset release.
    task automatic measure_after_release(input string name);
        int first_on;
        int slow_r [2];
        int slow_g [2];
        int slow_b [2];
        int mid_r  [2];
        int p;
        first_on = -1;
        for (int i = 0; i < 2; i++) begin
            slow_r[i] = 0; slow_g[i] = 0; slow_b[i] = 0; mid_r[i] = 0;
        end
        for (int k = 1; k <= 512; k++) begin
            @(negedge clk);
            p = (k > 256) ? 1 : 0;
            if (slow_if.RGB_R == ON_LVL) begin
                slow_r[p]++;
                if (first_on < 0) first_on = k;
            end
            if (slow_if.RGB_G == ON_LVL) slow_g[p]++;
            if (slow_if.RGB_B == ON_LVL) slow_b[p]++;
            if (mid_if.RGB_R == ON_LVL)  mid_r[p]++;
        end
        check_count({name, "_first_on_r"}, first_on, 257);
        check_count({name, "_slow_r_duty0"}, slow_r[0], 0);
        check_count({name, "_slow_g_duty0"}, slow_g[0], 0);
        check_count({name, "_slow_r_128"}, slow_r[1], 128);
        check_count({name, "_slow_g_239"}, slow_g[1], 239);
        check_count({name, "_slow_b_17"}, slow_b[1], 17);
        check_count({name, "_mid_r_duty0"}, mid_r[0], 0);
        check_count({name, "_mid_r_255"}, mid_r[1], 255);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        check_count("model_p0",   model_target(0),   128);
        check_count("model_p64",  model_target(64),  255);
        check_count("model_p128", model_target(128), 128);
        check_count("model_p192", model_target(192), 1);
        check_count("model_p85",  model_target(85),  239);
        check_count("model_p171", model_target(171), 17);

        apply_stimulus(3, "reset");
        checking = 1'b1;
        measure_after_release("boot");

        repeat (65536 - 512) @(negedge clk);

        for (int i = 0; i < 256 && (cyc % 256) != 100; i++) @(negedge clk);
        check_count("align_pwm100", cyc % 256, 100);
        apply_stimulus(1, "midreset");
        measure_after_release("rerun");

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
